// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 80x25 text-mode VGA timing, character addressing and underline cursor; define CURSOR_BLINK_EN for a 32-frame cursor blink
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 400,
   parameter int V_FP     = 12,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 35
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [14:0] cursor_pos,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_blank,
   output logic [10:0] char_addr,
   output logic [3:0]  glyph_row,
   output logic [2:0]  glyph_col,
   output logic        cursor_hit,
   output logic        frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int HS_BEG = H_ACTIVE + H_FP;
   localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_BEG = V_ACTIVE + V_FP;
   localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
   logic [10:0]   addr_q, addr_d, addr_c;
   logic [3:0]    row_q, row_d;
   logic [2:0]    col_q, col_d;
   logic          hit_q, hit_d, fs_q, fs_d;
   logic          h_wrap, v_wrap, blank_c, blink_on;
   // pixel and line counters with end-of-line and end-of-frame wrap
   always_comb begin
      h_wrap = int'(h_q) == H_TOTAL - 1;
      v_wrap = h_wrap && int'(v_q) == V_TOTAL - 1;
      h_d = h_wrap ? '0 : h_q + 1'b1;
      v_d = v_wrap ? '0 : h_wrap ? v_q + 1'b1 : v_q;
   end
`ifdef CURSOR_BLINK_EN
   logic [4:0] frame_q, frame_d;
   // frame counter; its MSB hides the cursor for 16 of every 32 frames
   always_comb begin
      frame_d = v_wrap ? frame_q + 5'd1 : frame_q;
      blink_on = ~frame_q[4];
   end
   // frame counter register
   always_ff @(posedge clk) begin
      if (reset) frame_q <= '0;
      else frame_q <= frame_d;
   end
`else
   assign blink_on = 1'b1;
`endif
   // decode the current counters into the next registered outputs
   always_comb begin
      blank_c = int'(h_q) >= H_ACTIVE || int'(v_q) >= V_ACTIVE;
      addr_c = 11'(v_q >> 4) * 11'(H_ACTIVE / 8) + 11'(h_q >> 3);
      hsync_d = !(int'(h_q) >= HS_BEG && int'(h_q) < HS_END);
      vsync_d = !(int'(v_q) >= VS_BEG && int'(v_q) < VS_END);
      blank_d = blank_c;
      addr_d = blank_c ? addr_q : addr_c;
      row_d = v_q[3:0];
      col_d = h_q[2:0];
      hit_d = !blank_c && cursor_pos[14:11] == 4'd0 && addr_c == cursor_pos[10:0] && v_q[3:0] >= 4'd14 && blink_on;
      fs_d = h_q == '0 && v_q == '0;
   end
   // counter and output registers; reset restarts the raster at (0,0) with syncs idle
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         blank_q <= 1'b1;
         addr_q <= '0;
         row_q <= '0;
         col_q <= '0;
         hit_q <= 1'b0;
         fs_q <= 1'b0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         blank_q <= blank_d;
         addr_q <= addr_d;
         row_q <= row_d;
         col_q <= col_d;
         hit_q <= hit_d;
         fs_q <= fs_d;
      end
   end
   assign vga_hsync = hsync_q;
   assign vga_vsync = vsync_q;
   assign vga_blank = blank_q;
   assign char_addr = addr_q;
   assign glyph_row = row_q;
   assign glyph_col = col_q;
   assign cursor_hit = hit_q;
   assign frame_start = fs_q;
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Pixel-timing generator for the 80x25 text-mode display path: 640x400 active, 8x16 glyphs, pixel clock 25.2 MHz.
- Produces the active-low vga_hsync/vga_vsync consumed by the VGA register file (status bit) and the monitor.
- Also produces text-buffer character address, glyph row/column, blanking and a cursor-hit flag for the downstream glyph/pixel stage.
- Cursor position comes from the register file's cursor_pos.

Parameters:
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FP, 16, horizontal front porch pixels
- H_SYNC, 96, horizontal sync pulse pixels
- H_BP, 48, horizontal back porch pixels
- V_ACTIVE, 400, visible lines (multiple of 16)
- V_FP, 12, vertical front porch lines
- V_SYNC, 2, vertical sync pulse lines
- V_BP, 35, vertical back porch lines

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- cursor_pos  in  15  cursor character index from the register file
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_blank  out  1  1 outside the active area
- char_addr  out  11  text-buffer character index, row*80+col
- glyph_row  out  4  scanline within the character cell
- glyph_col  out  3  pixel within the character cell
- cursor_hit  out  1  current pixel is a lit cursor pixel
- frame_start  out  1  one-cycle pulse at pixel (0,0)

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high, sampled on posedge clk.
- Counters:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = sum of the four H params (800).
  - v_cnt counts 0..V_TOTAL-1 (449).
  - h_cnt increments every cycle; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1, on the same cycle.
- Latency: every output is registered from the current (h_cnt, v_cnt), so outputs lag the counters by exactly 1 cycle. All outputs are mutually aligned.
- Decode (per counter value):
  - hsync low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (412..413).
  - blank = (h_cnt >= H_ACTIVE) | (v_cnt >= V_ACTIVE).
  - glyph_col = h_cnt[2:0]; glyph_row = v_cnt[3:0].
  - char_addr = (v_cnt>>4)*(H_ACTIVE/8) + (h_cnt>>3), truncated to 11 bits. Valid only when not blanked; when blanked, char_addr holds its last active value.
  - Maximum char_addr is 1999 at (639,399).
  - frame_start = (h_cnt==0 & v_cnt==0).
- Cursor:
  - cursor_hit = ~blank & (cursor_pos[14:11]==0) & (char_addr==cursor_pos[10:0]) & (glyph_row >= 14) & blink_on.
  - This gives an underline cursor on scanlines 14-15. The comparison uses the same-cycle decoded values.
  - cursor_pos out of range (>1999) never hits.
  - cursor_pos is sampled every cycle; a change mid-frame takes effect on the next pixel.
- Frame counter: 5-bit frame_cnt increments at each v_cnt wrap and wraps 31 -> 0.
- Reset:
  - h_cnt=0, v_cnt=0, frame_cnt=0.
  - Outputs: vga_hsync=1, vga_vsync=1, vga_blank=1, char_addr=0, glyph_row=0, glyph_col=0, cursor_hit=0, frame_start=0.
  - The first cycle after reset deassertion presents the outputs for (0,0): frame_start=1, blank=0.
- Reset mid-frame: counters restart at (0,0) on the next edge; no partial sync pulse is extended.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined: blink_on = ~frame_cnt[4], i.e. the cursor is visible for 16 frames, then hidden for 16 frames, starting visible after reset.
- Undefined: blink_on = 1 constantly, and frame_cnt is not implemented.

Test Plan:
- Reset held 3 cycles then released -> during reset hsync=vsync=blank=1, cursor_hit=0; first output cycle after release frame_start=1, blank=0, char_addr=0.
- Run one line -> vga_hsync low for exactly 96 cycles starting at output cycle h=656; blank rises at h=640; line period 800 cycles.
- Run one frame -> vga_vsync low for 2 lines (v=412,413); frame_start period 359200 cycles.
- Pixel (639,399) -> char_addr=1999, glyph_row=15, glyph_col=7, blank=0; pixel (640,399) -> blank=1.
- cursor_pos=81 -> cursor_hit=1 only for h=8..15 on v=30,31 (char row 1, col 1); cursor_pos=2000 -> cursor_hit never 1.
- With CURSOR_BLINK_EN: cursor_pos=0 -> hits in frames 0-15, none in frames 16-31, hits again in frame 32. Assert reset at v=200 -> next output shows frame_start=1 and frame_cnt restarts at 0.
